// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: serial circle-set candidate counter over the fixed 8x8 grid.
// One squared-distance/compare unit is time-shared across the three circles;
// each EVAL cycle tests one (point, circle) pair and stores its flag.
module set_scan_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  candidate
);

  localparam int unsigned CW   = 4;  // coordinate / radius width
  localparam int unsigned PW   = 3;  // grid index width (0..7 encodes 1..8)
  localparam int unsigned SQW  = 8;  // square width
  localparam int unsigned SUMW = 9;  // distance-squared sum width
  localparam int unsigned CNTW = 7;  // point counter width (0..64)

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [23:0]       central_q;
  logic [11:0]       radius_q;
  logic [1:0]        mode_q;
  logic [PW-1:0]     px_q, py_q;
  logic [1:0]        circ_q;
  logic [2:0]        flags_q;
  logic [CNTW-1:0]   count_q;
  logic              latch_c;

  logic [CW-1:0]     cx_c, cy_c, r_c, xv_c, yv_c, dx_c, dy_c;
  logic [SQW-1:0]    sqx_c, sqy_c, r2_c;
  logic [SUMW-1:0]   sum_c;
  logic              inside_c, member_c, last_circ_c, last_point_c;
  logic [1:0]        k_last_c;

  // Select the circle under evaluation and test the current grid point against it
  always_comb begin
    cx_c = central_q[7:4];
    cy_c = central_q[3:0];
    r_c  = radius_q[3:0];
    case (circ_q)
      2'd0: begin cx_c = central_q[23:20]; cy_c = central_q[19:16]; r_c = radius_q[11:8]; end
      2'd1: begin cx_c = central_q[15:12]; cy_c = central_q[11:8];  r_c = radius_q[7:4];  end
      default: ;
    endcase
    xv_c     = CW'({1'b0, px_q}) + CW'(1);
    yv_c     = CW'({1'b0, py_q}) + CW'(1);
    dx_c     = (xv_c >= cx_c) ? (xv_c - cx_c) : (cx_c - xv_c);
    dy_c     = (yv_c >= cy_c) ? (yv_c - cy_c) : (cy_c - yv_c);
    sqx_c    = SQW'(dx_c) * SQW'(dx_c);
    sqy_c    = SQW'(dy_c) * SQW'(dy_c);
    r2_c     = SQW'(r_c) * SQW'(r_c);
    sum_c    = SUMW'(sqx_c) + SUMW'(sqy_c);
    inside_c = (sum_c <= SUMW'(r2_c));
  end

  // Combine stored flags with the last circle's result according to the latched mode
  always_comb begin
    k_last_c = 2'd0;
    member_c = inside_c;
    case (mode_q)
      2'd1: begin k_last_c = 2'd1; member_c = flags_q[0] & inside_c; end
      2'd2: begin k_last_c = 2'd1; member_c = flags_q[0] ^ inside_c; end
      2'd3: begin
        k_last_c = 2'd2;
        member_c = ((2'(flags_q[0]) + 2'(flags_q[1]) + 2'(inside_c)) == 2'd2);
      end
      default: ;
    endcase
    last_circ_c  = (circ_q == k_last_c);
    last_point_c = (px_q == PW'(7)) && (py_q == PW'(7));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    latch_c = 1'b0;
    case (state_q)
      S_IDLE: if (en) begin
        latch_c = 1'b1;
        state_d = S_EVAL;
      end
      S_EVAL: if (last_circ_c && last_point_c) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job latch, scan position, flags, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      circ_q    <= '0;
      flags_q   <= '0;
      count_q   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
    end else begin
      busy  <= (state_d != S_IDLE);
      valid <= (state_d == S_DONE);
      if (latch_c) begin
        central_q <= central;
        radius_q  <= radius;
        mode_q    <= mode;
        px_q      <= '0;
        py_q      <= '0;
        circ_q    <= '0;
        flags_q   <= '0;
        count_q   <= '0;
      end else if (state_q == S_EVAL) begin
        case (circ_q)
          2'd0:    flags_q[0] <= inside_c;
          2'd1:    flags_q[1] <= inside_c;
          default: flags_q[2] <= inside_c;
        endcase
        if (!last_circ_c) begin
          circ_q <= circ_q + 2'd1;
        end else begin
          circ_q  <= '0;
          count_q <= count_q + CNTW'(member_c);
          px_q    <= px_q + PW'(1);
          if (px_q == PW'(7)) py_q <= py_q + PW'(1);
          if (last_point_c) candidate <= 8'(count_q + CNTW'(member_c));
        end
      end
    end
  end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Directed self-checking bench for set_scan_ctrl.
module tb_set_scan_ctrl;

  logic        clk, rst, en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy, valid;
  logic [7:0]  candidate;

  int checks = 0;
  int errors = 0;
  int prev_cand = 0;

  set_scan_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] cen(input int x1, y1, x2, y2, x3, y3);
    return {4'(x1), 4'(y1), 4'(x2), 4'(y2), 4'(x3), 4'(y3)};
  endfunction

  function automatic logic [11:0] rad(input int r1, r2, r3);
    return {4'(r1), 4'(r2), 4'(r3)};
  endfunction

  // Start a job from an idle cycle (called #1 after a posedge), check latency and result
  task automatic run_job(input string tag, input logic [23:0] c, input logic [11:0] r,
                         input logic [1:0] m, input int exp_cand, input int exp_lat);
    int n;
    central = c; radius = r; mode = m; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    n = 1;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_cand_hold"}, candidate, prev_cand);
    while (!valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_cand"}, candidate, exp_cand);
    chk({tag, "_busy_done"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_valid_pulse"}, valid, 0);
    chk({tag, "_cand_keep"}, candidate, exp_cand);
    prev_cand = exp_cand;
  endtask

  initial begin
    int n;
    int nvalid;
    rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cand", candidate, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job("m0_basic", cen(4,4,0,0,0,0), rad(2,0,0), 2'd0, 13, 65);
    run_job("m1_and",   cen(4,4,5,4,0,0), rad(2,2,0), 2'd1, 8, 129);
    run_job("m2_xor",   cen(4,4,5,4,0,0), rad(2,2,0), 2'd2, 10, 129);
    run_job("m3_two",   cen(4,4,4,4,4,4), rad(2,2,0), 2'd3, 12, 193);
    run_job("ext_full", cen(8,8,0,0,0,0), rad(15,0,0), 2'd0, 64, 65);
    run_job("ext_zero", cen(0,0,0,0,0,0), rad(0,0,0), 2'd0, 0, 65);
    run_job("ext_one",  cen(1,1,0,0,0,0), rad(0,0,0), 2'd0, 1, 65);

    // en held high: mid-job input change must not disturb job 1; job 2 starts right after
    central = cen(4,4,0,0,0,0); radius = rad(2,0,0); mode = 2'd0; en = 1'b1;
    @(posedge clk); #1;
    central = cen(8,8,0,0,0,0); radius = rad(15,0,0); mode = 2'd3;
    n = 1; nvalid = 0;
    while (!valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_lat1", n, 65);
    chk("b2b_cand1", candidate, 13);
    central = cen(1,1,0,0,0,0); radius = rad(0,0,0); mode = 2'd0;
    @(posedge clk); #1;
    chk("b2b_gap_idle", busy, 0);
    chk("b2b_gap_valid", valid, 0);
    @(posedge clk); #1;
    en = 1'b0;
    chk("b2b_restart", busy, 1);
    n = 1;
    while (n < 80) begin
      if (valid) nvalid++;
      if (valid) chk("b2b_lat2", n, 65);
      if (valid) chk("b2b_cand2", candidate, 1);
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_one_valid", nvalid, 1);
    prev_cand = 1;

    // Reset 40 cycles into a mode-3 job aborts it
    central = cen(4,4,4,4,4,4); radius = rad(2,2,0); mode = 2'd3; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_cand", candidate, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nvalid = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
    chk("abort_idle", busy, 0);
    prev_cand = 0;
    run_job("post_rst", cen(4,4,0,0,0,0), rad(2,0,0), 2'd0, 13, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_scan_ctrl.md
# set_scan_ctrl

Sequencing controller for the circle-set candidate count: latches one job (three circle centres, three radii, mode), then scans the 8x8 grid point by point. It time-shares a single squared-distance/compare unit across the three circles, combines the per-circle membership flags according to mode, and reports the number of qualifying grid points. It is the serial, area-lean alternative to the 64-instance parallel subset array and presents the same job-level port set, so it drops into the same top-level slot.

## Interface
Parameters: none (grid fixed at 8x8, coordinates 1..8).
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  job request; sampled only while busy=0
- central  in  24  {x1,y1,x2,y2,x3,y3}, 4-bit unsigned each, [23:20]=x1 … [3:0]=y3
- radius  in  12  {r1,r2,r3}, 4-bit unsigned each, [11:8]=r1
- mode  in  2  set function, see Operation
- busy  out  1  job in progress; new en ignored while high
- valid  out  1  one-cycle pulse: candidate holds the new result
- candidate  out  8  count of grid points satisfying mode (0..64)

## Operation
- Sets: A, B, C = grid points (x,y), x,y in 1..8, with (x-cx)^2+(y-cy)^2 <= r^2 for circles 1, 2, 3.
- mode 0: A. mode 1: A∩B. mode 2: A xor B (exactly one of A,B). mode 3: exactly two of A,B,C.
- Circles per point K: mode 0 -> 1, modes 1/2 -> 2, mode 3 -> 3.
- Arithmetic: |x-cx| via unsigned absolute difference (4 bits, max 14); squares 8 bits; sum 9 bits (max 392); r^2 8 bits (max 225); compare unsigned, inclusive (<=). Centres 0 and 9..15 are legal and computed arithmetically.
- Shared unit evaluates exactly one (point, circle) pair per cycle; flag stored in a 3-bit flag register.
- Counter 7 bits internal, zero-extended to candidate.
- FSM:
  - IDLE: busy=0. en=1 -> latch central/radius/mode, clear counter and flags, point=(1,1), circle=0 -> EVAL.
  - EVAL: evaluate (point, circle). If circle<K-1: circle++. Else: combine flags per latched mode, counter += member, circle=0, advance x; x wrap 8->1 increments y. On last circle of (8,8) -> DONE.
  - DONE: candidate <= final count (including the (8,8) result), valid=1 -> IDLE.
- Scan order: x inner (1..8), y outer (1..8).
- Input changes after latch have no effect on the running job.

## Timing
- Reset: state IDLE, busy=0, valid=0, candidate=0, counter/flags 0.
- Reset mid-job: aborts immediately; no valid pulse; candidate returns to 0.
- en sampled at edge t (busy=0): busy=1 from t+1; 64*K EVAL cycles; DONE cycle with valid=1 and new candidate in cycle t+64K+1; busy stays 1 through DONE, 0 from the next cycle.
- Latency en-edge to valid: 65 (mode 0), 129 (modes 1/2), 193 (mode 3) cycles.
- en while busy=1 (including the DONE cycle): ignored, not queued.
- Earliest next job: en high in the first busy=0 cycle; back-to-back gap of exactly one idle cycle.
- candidate holds its value between valid pulses; it changes only in the DONE cycle.
- valid is never high for more than one consecutive cycle.

## Test plan
- Mode 0, A=(4,4), r1=2, en pulse -> valid exactly 65 cycles after the en edge, candidate=13, busy high 65 cycles.
- Modes 1 and 2, A=(4,4), r1=2, B=(5,4), r2=2 -> mode 1 candidate=8 at 129 cycles; mode 2 candidate=10 at 129 cycles.
- Mode 3, A=B=(4,4), r1=r2=2, C=(4,4), r3=0 -> candidate=12 at 193 cycles.
- Extremes, mode 0: A=(8,8), r1=15 -> 64. A=(0,0), r1=0 -> 0. A=(1,1), r1=0 -> 1.
- en held high continuously with a second job's inputs, plus input changes mid-job -> first result unaffected; second job starts in the first busy=0 cycle; exactly one valid per job.
- rst asserted at cycle 40 of a mode-3 job -> busy=0, valid=0, candidate=0 immediately; no later valid. A following mode-0 job yields its correct result.
